// File: rtl/formula_n_isqrt_pkg.sv
// Shared types and helpers for the N-argument sum-of-square-roots controller.
package formula_n_isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of a counter that must hold values 0..n_args.
    function automatic int cnt_width(input int n_args);
        return (n_args < 1) ? 1 : $clog2(n_args + 1);
    endfunction

endpackage

// File: rtl/formula_n_isqrt_pipe_fsm.sv
// Controller that streams N_ARGS operands into a shared pipelined isqrt and
// sums the returned roots. One job in flight at a time; completion is found
// purely by counting returned results, so the isqrt latency need not be known.
module formula_n_isqrt_pipe_fsm
    import formula_n_isqrt_pkg::*;
#(
    parameter int N_ARGS = 3,
    parameter int W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arg_vld,
    output logic                arg_rdy,
    input  logic [N_ARGS*W-1:0] args,
    output logic                res_vld,
    output logic [W-1:0]        res,
    output logic                isqrt_x_vld,
    output logic [W-1:0]        isqrt_x,
    input  logic                isqrt_y_vld,
    input  logic [W/2-1:0]      isqrt_y
);

    localparam int             CW       = cnt_width(N_ARGS);
    localparam logic [CW-1:0]  LAST_IDX = CW'(N_ARGS - 1);

    // Reject parameter sets where the root width is fractional or the sum
    // could overflow the W-bit accumulator.
    generate
        if ((W % 2) != 0) begin : g_bad_w
            $error("formula_n_isqrt_pipe_fsm: W must be even");
        end
        if (N_ARGS < 1) begin : g_bad_n_low
            $error("formula_n_isqrt_pipe_fsm: N_ARGS must be at least 1");
        end
        if (((W / 2) < 31) && (N_ARGS > (1 << (W / 2)))) begin : g_bad_n_high
            $error("formula_n_isqrt_pipe_fsm: N_ARGS exceeds 2**(W/2)");
        end
    endgenerate

    state_t                state_q, state_d;
    logic [N_ARGS*W-1:0]   arg_q, arg_d;
    logic [W-1:0]          acc_q, acc_d;
    logic [CW-1:0]         issue_idx_q, issue_idx_d;
    logic [CW-1:0]         rcv_cnt_q, rcv_cnt_d;
    logic                  res_vld_q, res_vld_d;
    logic [W-1:0]          res_q, res_d;

    logic [W-1:0]          arg_word [N_ARGS];
    logic [W-1:0]          issue_word;
    logic [W-1:0]          acc_sum;
    logic                  accept;
    logic                  y_take;
    logic                  y_last;

    generate
        for (genvar gi = 0; gi < N_ARGS; gi++) begin : g_unpack
            assign arg_word[gi] = arg_q[gi*W +: W];
        end
    endgenerate

    assign arg_rdy = (state_q == IDLE);
    assign accept  = arg_vld && arg_rdy;
    // Results are only meaningful while a job is open; anything seen in IDLE is junk.
    assign y_take  = isqrt_y_vld && (state_q != IDLE);
    assign y_last  = y_take && (rcv_cnt_q == LAST_IDX);
    assign acc_sum = acc_q + {{(W/2){1'b0}}, isqrt_y};
    assign res_vld = res_vld_q;
    assign res     = res_q;

    // Select the stored argument addressed by the issue index.
    always_comb begin
        issue_word = '0;
        for (int i = 0; i < N_ARGS; i++) begin
            if (issue_idx_q == CW'(i)) begin
                issue_word = arg_word[i];
            end
        end
    end

    // Next-state, operand drive, accumulation and completion.
    always_comb begin
        state_d     = state_q;
        arg_d       = arg_q;
        acc_d       = acc_q;
        issue_idx_d = issue_idx_q;
        rcv_cnt_d   = rcv_cnt_q;
        res_vld_d   = 1'b0;
        res_d       = res_q;
        isqrt_x_vld = 1'b0;
        isqrt_x     = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Argument 0 goes out straight from the input bus so no cycle is lost.
                    isqrt_x_vld = 1'b1;
                    isqrt_x     = args[W-1:0];
                    arg_d       = args;
                    acc_d       = '0;
                    issue_idx_d = CW'(1);
                    rcv_cnt_d   = '0;
                    state_d     = (N_ARGS == 1) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                isqrt_x_vld = 1'b1;
                isqrt_x     = issue_word;
                issue_idx_d = issue_idx_q + CW'(1);
                if (issue_idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (y_take) begin
            acc_d     = acc_sum;
            rcv_cnt_d = rcv_cnt_q + CW'(1);
        end
        // The last result closes the job regardless of whether issuing has finished.
        if (y_last) begin
            state_d   = IDLE;
            res_vld_d = 1'b1;
            res_d     = acc_sum;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            arg_q       <= '0;
            acc_q       <= '0;
            issue_idx_q <= '0;
            rcv_cnt_q   <= '0;
            res_vld_q   <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            arg_q       <= arg_d;
            acc_q       <= acc_d;
            issue_idx_q <= issue_idx_d;
            rcv_cnt_q   <= rcv_cnt_d;
            res_vld_q   <= res_vld_d;
            res_q       <= res_d;
        end
    end

endmodule

// File: tb/tb_formula_n_isqrt_pipe_fsm.sv
// Directed bench for the sum-of-square-roots controller. Four instances are
// exercised, each paired with a simple fixed-latency isqrt stand-in.
module tb_formula_n_isqrt_pipe_fsm;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    // Reference integer square root of a 32-bit value.
    function automatic logic [15:0] isqrt_f(input logic [31:0] v);
        logic [15:0]     r;
        longint unsigned t;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            t = {48'd0, r} | (64'd1 << i);
            if (t * t <= {32'd0, v}) r = t[15:0];
        end
        return r;
    endfunction

    // ---------------- instance a: N_ARGS=3, W=32, L=4 ----------------
    logic        a_arg_vld, a_arg_rdy, a_res_vld, a_x_vld, a_y_vld, a_force;
    logic [95:0] a_args;
    logic [31:0] a_res, a_x;
    logic [15:0] a_y;
    logic [3:0]  a_pv;
    logic [15:0] a_pd [4];

    assign a_y_vld = a_force | a_pv[3];
    assign a_y     = a_force ? 16'd55 : a_pd[3];

    // isqrt stand-in, latency 4
    always @(posedge clk) begin
        if (rst) a_pv <= '0;
        else     a_pv <= {a_pv[2:0], a_x_vld};
        a_pd[0] <= isqrt_f(a_x);
        for (int i = 1; i < 4; i++) a_pd[i] <= a_pd[i-1];
    end

    formula_n_isqrt_pipe_fsm #(.N_ARGS(3), .W(32)) dut_a (
        .clk(clk), .rst(rst), .arg_vld(a_arg_vld), .arg_rdy(a_arg_rdy), .args(a_args),
        .res_vld(a_res_vld), .res(a_res), .isqrt_x_vld(a_x_vld), .isqrt_x(a_x),
        .isqrt_y_vld(a_y_vld), .isqrt_y(a_y)
    );

    // ---------------- instance b: N_ARGS=1, W=32, L=1 ----------------
    logic        b_arg_vld, b_arg_rdy, b_res_vld, b_x_vld, b_pv;
    logic [31:0] b_args, b_res, b_x;
    logic [15:0] b_pd;

    // isqrt stand-in, latency 1
    always @(posedge clk) begin
        if (rst) b_pv <= 1'b0;
        else     b_pv <= b_x_vld;
        b_pd <= isqrt_f(b_x);
    end

    formula_n_isqrt_pipe_fsm #(.N_ARGS(1), .W(32)) dut_b (
        .clk(clk), .rst(rst), .arg_vld(b_arg_vld), .arg_rdy(b_arg_rdy), .args(b_args),
        .res_vld(b_res_vld), .res(b_res), .isqrt_x_vld(b_x_vld), .isqrt_x(b_x),
        .isqrt_y_vld(b_pv), .isqrt_y(b_pd)
    );

    // ---------------- instance c: N_ARGS=8, W=16, L=1 ----------------
    logic         c_arg_vld, c_arg_rdy, c_res_vld, c_x_vld, c_pv;
    logic [127:0] c_args;
    logic [15:0]  c_res, c_x;
    logic [7:0]   c_pd;

    // isqrt stand-in, latency 1
    always @(posedge clk) begin
        if (rst) c_pv <= 1'b0;
        else     c_pv <= c_x_vld;
        c_pd <= 8'(isqrt_f({16'd0, c_x}));
    end

    formula_n_isqrt_pipe_fsm #(.N_ARGS(8), .W(16)) dut_c (
        .clk(clk), .rst(rst), .arg_vld(c_arg_vld), .arg_rdy(c_arg_rdy), .args(c_args),
        .res_vld(c_res_vld), .res(c_res), .isqrt_x_vld(c_x_vld), .isqrt_x(c_x),
        .isqrt_y_vld(c_pv), .isqrt_y(c_pd)
    );

    // ---------------- instance d: N_ARGS=8, W=16, L=5 ----------------
    logic         d_arg_vld, d_arg_rdy, d_res_vld, d_x_vld;
    logic [127:0] d_args;
    logic [15:0]  d_res, d_x;
    logic [4:0]   d_pv;
    logic [7:0]   d_pd [5];

    // isqrt stand-in, latency 5
    always @(posedge clk) begin
        if (rst) d_pv <= '0;
        else     d_pv <= {d_pv[3:0], d_x_vld};
        d_pd[0] <= 8'(isqrt_f({16'd0, d_x}));
        for (int i = 1; i < 5; i++) d_pd[i] <= d_pd[i-1];
    end

    formula_n_isqrt_pipe_fsm #(.N_ARGS(8), .W(16)) dut_d (
        .clk(clk), .rst(rst), .arg_vld(d_arg_vld), .arg_rdy(d_arg_rdy), .args(d_args),
        .res_vld(d_res_vld), .res(d_res), .isqrt_x_vld(d_x_vld), .isqrt_x(d_x),
        .isqrt_y_vld(d_pv[4]), .isqrt_y(d_pd[4])
    );

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (a_arg_rdy !== 1'b1) begin n_fails++; $display("FAIL reset_rdy: got %b want 1", a_arg_rdy); end
        n_checks++; if (a_res_vld !== 1'b0) begin n_fails++; $display("FAIL reset_res_vld: got %b want 0", a_res_vld); end
        n_checks++; if (a_res !== 32'd0) begin n_fails++; $display("FAIL reset_res: got %0d want 0", a_res); end
        n_checks++; if (a_x_vld !== 1'b0 || a_x !== 32'd0) begin n_fails++; $display("FAIL reset_x: got vld=%b x=%0h want 0/0", a_x_vld, a_x); end
        n_checks++; if (b_arg_rdy !== 1'b1 || c_arg_rdy !== 1'b1 || d_arg_rdy !== 1'b1) begin n_fails++; $display("FAIL reset_rdy_bcd: got %b%b%b want 111", b_arg_rdy, c_arg_rdy, d_arg_rdy); end
        $display("reset: done");
    endtask

    task automatic test_basic();
        int k;
        @(posedge clk); #1 a_args = {32'd25, 32'd16, 32'd9}; a_arg_vld = 1'b1;
        @(negedge clk);
        n_checks++; if (a_arg_rdy !== 1'b1) begin n_fails++; $display("FAIL basic_rdy: got %b want 1", a_arg_rdy); end
        n_checks++; if (a_x_vld !== 1'b1 || a_x !== 32'd9) begin n_fails++; $display("FAIL basic_issue0: got vld=%b x=%0d want 1/9", a_x_vld, a_x); end
        @(posedge clk); #1 a_arg_vld = 1'b0;
        @(negedge clk);
        n_checks++; if (a_x_vld !== 1'b1 || a_x !== 32'd16 || a_arg_rdy !== 1'b0) begin n_fails++; $display("FAIL basic_issue1: got vld=%b x=%0d rdy=%b want 1/16/0", a_x_vld, a_x, a_arg_rdy); end
        @(negedge clk);
        n_checks++; if (a_x_vld !== 1'b1 || a_x !== 32'd25) begin n_fails++; $display("FAIL basic_issue2: got vld=%b x=%0d want 1/25", a_x_vld, a_x); end
        @(negedge clk);
        n_checks++; if (a_x_vld !== 1'b0 || a_x !== 32'd0) begin n_fails++; $display("FAIL basic_idle_x: got vld=%b x=%0d want 0/0", a_x_vld, a_x); end
        k = 3;
        while (!a_res_vld && k < 40) begin @(negedge clk); k++; end
        n_checks++; if (k !== 7) begin n_fails++; $display("FAIL basic_latency: got %0d want 7", k); end
        n_checks++; if (a_res !== 32'd12) begin n_fails++; $display("FAIL basic_res: got %0d want 12", a_res); end
        $display("basic: args {9,16,25} res=%0d after %0d cycles", a_res, k);
        @(negedge clk);
        n_checks++; if (a_res_vld !== 1'b0 || a_res !== 32'd12) begin n_fails++; $display("FAIL basic_hold: got vld=%b res=%0d want 0/12", a_res_vld, a_res); end
    endtask

    task automatic test_back_to_back();
        int k;
        int rdy_bad;
        @(posedge clk); #1 a_args = {32'd4, 32'd1, 32'd0}; a_arg_vld = 1'b1;
        @(negedge clk);
        n_checks++; if (a_arg_rdy !== 1'b1) begin n_fails++; $display("FAIL b2b_rdy0: got %b want 1", a_arg_rdy); end
        @(posedge clk); #1 a_args = {3{32'hFFFF_FFFF}};
        k = 0; rdy_bad = 0;
        do begin
            @(negedge clk); k++;
            if (!a_res_vld && a_arg_rdy) rdy_bad++;
        end while (!a_res_vld && k < 40);
        n_checks++; if (k !== 7) begin n_fails++; $display("FAIL b2b_spacing1: got %0d want 7", k); end
        n_checks++; if (a_res !== 32'd3) begin n_fails++; $display("FAIL b2b_res1: got %0d want 3", a_res); end
        n_checks++; if (a_arg_rdy !== 1'b1) begin n_fails++; $display("FAIL b2b_rdy_at_res: got %b want 1", a_arg_rdy); end
        $display("b2b: job1 res=%0d after %0d cycles", a_res, k);
        @(posedge clk); #1 a_arg_vld = 1'b0;
        k = 0;
        do begin
            @(negedge clk); k++;
            if (!a_res_vld && a_arg_rdy) rdy_bad++;
        end while (!a_res_vld && k < 40);
        n_checks++; if (k !== 7) begin n_fails++; $display("FAIL b2b_spacing2: got %0d want 7", k); end
        n_checks++; if (a_res !== 32'd196605) begin n_fails++; $display("FAIL b2b_res2: got %0d want 196605", a_res); end
        n_checks++; if (rdy_bad !== 0) begin n_fails++; $display("FAIL b2b_rdy_busy: got %0d busy-ready cycles want 0", rdy_bad); end
        $display("b2b: job2 res=%0d after %0d cycles", a_res, k);
    endtask

    task automatic test_single();
        int k;
        int rdy_bad;
        @(posedge clk); #1 b_args = 32'd100; b_arg_vld = 1'b1;
        @(negedge clk);
        n_checks++; if (b_x_vld !== 1'b1 || b_x !== 32'd100) begin n_fails++; $display("FAIL single_issue: got vld=%b x=%0d want 1/100", b_x_vld, b_x); end
        @(posedge clk); #1 b_args = 32'd144;
        k = 0; rdy_bad = 0;
        do begin
            @(negedge clk); k++;
            if (!b_res_vld && b_arg_rdy) rdy_bad++;
        end while (!b_res_vld && k < 20);
        n_checks++; if (k !== 2) begin n_fails++; $display("FAIL single_latency1: got %0d want 2", k); end
        n_checks++; if (b_res !== 32'd10 || b_arg_rdy !== 1'b1) begin n_fails++; $display("FAIL single_res1: got res=%0d rdy=%b want 10/1", b_res, b_arg_rdy); end
        $display("single: job1 res=%0d after %0d cycles", b_res, k);
        @(posedge clk); #1 b_arg_vld = 1'b0;
        k = 0;
        do begin
            @(negedge clk); k++;
            if (!b_res_vld && b_arg_rdy) rdy_bad++;
        end while (!b_res_vld && k < 20);
        n_checks++; if (k !== 2) begin n_fails++; $display("FAIL single_period: got %0d want 2", k); end
        n_checks++; if (b_res !== 32'd12) begin n_fails++; $display("FAIL single_res2: got %0d want 12", b_res); end
        n_checks++; if (rdy_bad !== 0) begin n_fails++; $display("FAIL single_rdy_busy: got %0d want 0", rdy_bad); end
        $display("single: job2 res=%0d after %0d cycles", b_res, k);
    endtask

    task automatic test_spurious();
        int k;
        @(posedge clk); #1 a_force = 1'b1;
        @(posedge clk); #1 a_force = 1'b0;
        @(negedge clk);
        n_checks++; if (a_res_vld !== 1'b0) begin n_fails++; $display("FAIL spurious_no_res: got %b want 0", a_res_vld); end
        a_args = {32'd1, 32'd1, 32'd1}; a_arg_vld = 1'b1;
        @(posedge clk); #1 a_arg_vld = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!a_res_vld && k < 40);
        n_checks++; if (k !== 7) begin n_fails++; $display("FAIL spurious_latency: got %0d want 7", k); end
        n_checks++; if (a_res !== 32'd3) begin n_fails++; $display("FAIL spurious_res: got %0d want 3", a_res); end
        $display("spurious: job {1,1,1} res=%0d", a_res);
    endtask

    task automatic test_reset_mid();
        int k;
        int res_seen;
        @(posedge clk); #1 a_args = {3{32'd9}}; a_arg_vld = 1'b1;
        @(posedge clk); #1 a_arg_vld = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (a_arg_rdy !== 1'b1 || a_res_vld !== 1'b0) begin n_fails++; $display("FAIL rstmid_ctrl: got rdy=%b vld=%b want 1/0", a_arg_rdy, a_res_vld); end
        n_checks++; if (a_res !== 32'd0) begin n_fails++; $display("FAIL rstmid_res: got %0d want 0", a_res); end
        n_checks++; if (a_x_vld !== 1'b0 || a_x !== 32'd0) begin n_fails++; $display("FAIL rstmid_x: got vld=%b x=%0d want 0/0", a_x_vld, a_x); end
        res_seen = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (a_res_vld) res_seen++; end
        n_checks++; if (res_seen !== 0) begin n_fails++; $display("FAIL rstmid_dropped: got %0d strobes want 0", res_seen); end
        a_args = {3{32'd4}}; a_arg_vld = 1'b1;
        @(posedge clk); #1 a_arg_vld = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!a_res_vld && k < 40);
        n_checks++; if (k !== 7 || a_res !== 32'd6) begin n_fails++; $display("FAIL rstmid_next_job: got res=%0d k=%0d want 6/7", a_res, k); end
        $display("reset_mid: following job {4,4,4} res=%0d", a_res);
    endtask

    task automatic test_random();
        logic [127:0] tmp;
        logic [15:0]  w, exp_sum, c_got, d_got;
        int k, c_k, d_k, xbad, rdy_bad;
        bit c_done, d_done;
        for (int j = 0; j < 6; j++) begin
            exp_sum = '0;
            for (int i = 0; i < 8; i++) begin
                w = (j == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
                tmp[i*16 +: 16] = w;
                exp_sum = exp_sum + isqrt_f({16'd0, w});
            end
            @(posedge clk); #1 c_args = tmp; d_args = tmp; c_arg_vld = 1'b1; d_arg_vld = 1'b1;
            @(posedge clk); #1 c_arg_vld = 1'b0; d_arg_vld = 1'b0;
            k = 0; c_k = 0; d_k = 0; xbad = 0; rdy_bad = 0; c_done = 0; d_done = 0;
            c_got = '0; d_got = '0;
            do begin
                @(negedge clk); k++;
                if ($isunknown(c_x) || $isunknown(d_x)) xbad++;
                if (!c_done) begin
                    if (c_res_vld) begin c_done = 1; c_got = c_res; c_k = k; end
                    else if (c_arg_rdy) rdy_bad++;
                end
                if (!d_done) begin
                    if (d_res_vld) begin d_done = 1; d_got = d_res; d_k = k; end
                    else if (d_arg_rdy) rdy_bad++;
                end
            end while (!(c_done && d_done) && k < 60);
            n_checks++; if (c_got !== exp_sum) begin n_fails++; $display("FAIL rand_c_res[%0d]: got %0d want %0d", j, c_got, exp_sum); end
            n_checks++; if (d_got !== exp_sum) begin n_fails++; $display("FAIL rand_d_res[%0d]: got %0d want %0d", j, d_got, exp_sum); end
            n_checks++; if (c_k !== 9 || d_k !== 13) begin n_fails++; $display("FAIL rand_latency[%0d]: got c=%0d d=%0d want 9/13", j, c_k, d_k); end
            n_checks++; if (xbad !== 0 || rdy_bad !== 0) begin n_fails++; $display("FAIL rand_ports[%0d]: got xbad=%0d rdy_busy=%0d want 0/0", j, xbad, rdy_bad); end
            $display("random[%0d]: expected %0d, L1 res=%0d, L5 res=%0d", j, exp_sum, c_got, d_got);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_arg_vld = 1'b0; a_args = '0; a_force = 1'b0;
        b_arg_vld = 1'b0; b_args = '0;
        c_arg_vld = 1'b0; c_args = '0;
        d_arg_vld = 1'b0; d_args = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_single();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/formula_n_isqrt_pipe_fsm.md
# formula_n_isqrt_pipe_fsm

Parametrised pipeline-aware controller that computes res = isqrt(arg[0]) + … + isqrt(arg[N_ARGS-1]) using a single shared, externally instantiated pipelined isqrt. It sits beside that isqrt instance inside a top-level wrapper and drives its input port while consuming its output port. Unlike the fixed three-argument version, it generalises width and argument count, adds an arg_vld/arg_rdy handshake, and issues all arguments on consecutive cycles without waiting for earlier results. The block is not pipelined across jobs: one job is in flight at a time.

## Interface
- N_ARGS, 3, number of arguments per job; legal range 1..2^(W/2).
- W, 32, argument width; must be even. isqrt result width is W/2.
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high. The same rst must also reset the isqrt instance.
- arg_vld  input  1  job offer.
- arg_rdy  output  1  block can accept a job; high only in IDLE.
- args  input  N_ARGS*W  packed arguments; arg[i] = args[i*W +: W].
- res_vld  output  1  one-cycle result strobe.
- res  output  W  sum of square roots; valid while res_vld is high and held until the next accept.
- isqrt_x_vld  output  1  issue strobe to isqrt.
- isqrt_x  output  W  operand to isqrt.
- isqrt_y_vld  input  1  isqrt result strobe.
- isqrt_y  input  W/2  isqrt result.

## Operation
- States:
  - IDLE: arg_rdy=1.
  - ISSUE: issue the remaining arguments.
  - DRAIN: wait for the remaining results.
- IDLE, accept when arg_vld && arg_rdy:
  - Same cycle: isqrt_x_vld=1, isqrt_x=arg[0] taken combinationally from args.
  - Register args into arg_q, clear acc, set issue_idx=1 and rcv_cnt=0.
  - Next state is ISSUE, or DRAIN if N_ARGS==1.
- ISSUE:
  - Each cycle: isqrt_x_vld=1, isqrt_x=arg_q[issue_idx], then issue_idx++.
  - After issuing arg_q[N_ARGS-1], go to DRAIN.
  - Results arriving during ISSUE are accumulated.
- Accumulation: in ISSUE or DRAIN, when isqrt_y_vld, acc += zero-extended isqrt_y and rcv_cnt++.
- Completion: when isqrt_y_vld with rcv_cnt==N_ARGS-1, acc is updated, res_vld pulses next cycle with res = final acc, and state returns to IDLE.
- The DRAIN/completion condition is evaluated in ISSUE as well (the N_ARGS==1 case goes directly to DRAIN).
- When not issuing: isqrt_x_vld=0 and isqrt_x=0 (no X on the port).
- isqrt_y_vld in IDLE is ignored: no accumulation and no count.
- arg_vld while arg_rdy=0 is ignored; the offer is not consumed.
- Width: acc and res are W bits. N_ARGS ≤ 2^(W/2) guarantees no overflow. Checked by elaboration-time assertion along with even W.
- Issue order is arguments 0..N_ARGS-1. The sum is order-independent, so result order is not checked.

## Timing
- L = isqrt latency (issue to isqrt_y_vld), fixed, ≥1, unknown to this block. Completion is detected only by counting results.
- Accept at cycle T:
  - Issues at T..T+N_ARGS-1.
  - Results at T+L..T+L+N_ARGS-1.
  - res_vld at T+L+N_ARGS.
  - arg_rdy=1 again at T+L+N_ARGS, so a new accept is possible in the same cycle as res_vld.
- Throughput: one job per L+N_ARGS cycles.
- Reset values: state=IDLE, arg_rdy=1 (combinational from state), res_vld=0, res=0, isqrt_x_vld=0, isqrt_x=0, acc=0, counters=0.
- Reset mid-job: the job is dropped with no res_vld. The isqrt pipe is flushed by the shared rst, so no stale results reach the next job.

## Structure
- Package formula_n_isqrt_pkg:
  - State enum state_t {IDLE, ISSUE, DRAIN}.
  - Helper function for counter width $clog2(N_ARGS+1).
- No sub-module: the FSM, operand mux, counters and accumulator live in one module.
- The top wrapper formula_n_isqrt_pipe_fsm_top instantiates this block plus one isqrt.

## Test plan
- N_ARGS=3, W=32, L=4; args {9,16,25}, one accept → issues on 3 consecutive cycles; res_vld exactly 7 cycles after accept; res=12.
- Back-to-back jobs with arg_vld held high: {0,1,4} then {2^32-1, 2^32-1, 2^32-1} → res 3, then 196605; accept spacing exactly 7 cycles; arg_rdy low in between.
- N_ARGS=1, arg 100, L=1 → res_vld 2 cycles after accept; res=10; period 2 cycles.
- Spurious isqrt_y_vld=1, isqrt_y=55 in IDLE, then job {1,1,1} → res=3; junk not accumulated.
- rst asserted 2 cycles after accept of {9,9,9} → no res_vld; outputs at reset values next cycle; following job {4,4,4} gives res=6.
- N_ARGS=8, W=16 with random args and L∈{1,5} → res equals the reference model sum; isqrt_x never X; arg_rdy never high outside IDLE.
